// File: rtl/modport_dut.sv
// Command/response engine: MOSI commands against a register-array memory,
// READ/STATUS results returned on MISO through a small response FIFO.
module modport_dut #(
  parameter int MOSI_DATA_W = 64,
  parameter int ADDR_W      = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [MOSI_DATA_W-1:0] mosi_data_i,
  input  logic                   mosi_valid_i,
  output logic                   mosi_ready_o,
  output logic [MOSI_DATA_W-1:0] miso_data_o,
  output logic                   miso_valid_o,
  input  logic                   miso_ready_i
);

  localparam int W     = MOSI_DATA_W;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PW    = $clog2(FIFO_DEPTH);

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] OP_STAT = 2'b11;

  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);

  logic [31:0]     mem_q [DEPTH];
  logic [31:0]     wcnt_q;
  logic [31:0]     wcnt_d;
  logic [W-1:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0]   wptr_q;
  logic [PW-1:0]   rptr_q;
  logic [PW:0]     cnt_q;
  logic [PW:0]     cnt_d;

  logic [1:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              accept;
  logic              wr_en;
  logic              push;
  logic              pop;
  logic [W-1:0]      resp;

  assign op    = mosi_data_i[W-1 -: 2];
  assign addr  = mosi_data_i[W-3 -: ADDR_W];
  assign wdata = mosi_data_i[31:0];

  if (W - 2 - ADDR_W > 32) begin : g_unused
    logic unused_bits;
    assign unused_bits = ^mosi_data_i[W-3-ADDR_W:32];
  end

  // Ready comes only from the registered count, never from miso_ready_i.
  assign mosi_ready_o = (cnt_q != FULL);
  assign miso_valid_o = (cnt_q != '0);
  assign miso_data_o  = miso_valid_o ? fifo_q[rptr_q] : '0;

  assign accept = mosi_valid_i && mosi_ready_o;
  assign wr_en  = accept && (op == OP_WR);
  assign push   = accept && ((op == OP_RD) || (op == OP_STAT));
  assign pop    = miso_valid_o && miso_ready_i;

  always_comb begin
    resp           = '0;
    resp[W-1 -: 2] = op;
    resp[W-3 -: ADDR_W] = addr;
    unique case (op)
      OP_RD:   resp[31:0] = mem_q[addr];
      OP_STAT: resp[31:0] = wcnt_q;
      OP_NOP,
      OP_WR:   resp[31:0] = '0;
      default: resp[31:0] = '0;
    endcase
  end

  always_comb begin
    wcnt_d = wcnt_q;
    if (wr_en && (wcnt_q != 32'hFFFF_FFFF)) begin
      wcnt_d = wcnt_q + 32'd1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wcnt_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[addr] <= wdata;
      end
      wcnt_q <= wcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_q[wptr_q] <= resp;
    end
  end

endmodule

// File: tb/tb_modport_dut.sv
// Directed bench for modport_dut: vector table plus hand-written
// sequences for FIFO-full hold-off and reset with traffic in flight.
module tb_modport_dut;

  localparam int W  = 64;
  localparam int AW = 8;
  localparam int FD = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] mosi_data_i;
  logic         mosi_valid_i;
  logic         mosi_ready_o;
  logic [W-1:0] miso_data_o;
  logic         miso_valid_o;
  logic         miso_ready_i;

  int n_chk  = 0;
  int n_fail = 0;

  modport_dut #(
    .MOSI_DATA_W(W),
    .ADDR_W     (AW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mosi_data_i (mosi_data_i),
    .mosi_valid_i(mosi_valid_i),
    .mosi_ready_o(mosi_ready_o),
    .miso_data_o (miso_data_o),
    .miso_valid_o(miso_valid_o),
    .miso_ready_i(miso_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         mr;
    logic         er;
    logic         ev;
    logic [W-1:0] ed;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [W-1:0] word(logic [1:0] op, logic [AW-1:0] a,
                                        logic [31:0] d);
    logic [W-1:0] w;
    w = '0;
    w[W-1 -: 2]  = op;
    w[W-3 -: AW] = a;
    w[31:0]      = d;
    return w;
  endfunction

  task automatic chk(string name, logic [W-1:0] got, logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [W-1:0] d, logic mr);
    mosi_valid_i = v;
    mosi_data_i  = d;
    miso_ready_i = mr;
  endtask

  task automatic chk_out(string tag, logic er, logic ev, logic [W-1:0] ed);
    chk({tag, " ready"}, W'(mosi_ready_o), W'(er));
    chk({tag, " valid"}, W'(miso_valid_o), W'(ev));
    chk({tag, " data"},  miso_data_o, ed);
  endtask

  function automatic vec_t mk(logic v, logic [W-1:0] d, logic er, logic ev,
                              logic [W-1:0] ed);
    vec_t t;
    t.v  = v;
    t.d  = d;
    t.mr = 1'b1;
    t.er = er;
    t.ev = ev;
    t.ed = ed;
    return t;
  endfunction

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] WR  = 2'b01;
  localparam logic [1:0] RD  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  logic [W-1:0] junk;
  logic [W-1:0] z;

  initial begin
    z    = '0;
    junk = '0;
    junk[53:32] = 22'h2A_5A5A;

    // Each entry: inputs held this cycle, outputs expected this cycle.
    tbl.push_back(mk(0, z,                             1, 0, z));
    tbl.push_back(mk(1, word(ST, 8'h00, 0),            1, 0, z));
    tbl.push_back(mk(1, word(WR, 8'h12, 32'hDEADBEEF), 1, 1, word(ST, 8'h00, 0)));
    tbl.push_back(mk(1, word(RD, 8'h12, 0),            1, 0, z));
    tbl.push_back(mk(0, z,                             1, 1, word(RD, 8'h12, 32'hDEADBEEF)));
    tbl.push_back(mk(1, word(WR, 8'h01, 32'h1),        1, 0, z));
    tbl.push_back(mk(1, word(WR, 8'h02, 32'h2),        1, 0, z));
    tbl.push_back(mk(1, word(ST, 8'h05, 0),            1, 0, z));
    tbl.push_back(mk(1, word(RD, 8'h33, 0),            1, 1, word(ST, 8'h05, 32'd3)));
    tbl.push_back(mk(0, z,                             1, 1, word(RD, 8'h33, 0)));
    tbl.push_back(mk(0, z,                             1, 0, z));
    tbl.push_back(mk(1, word(WR, 8'h40, 32'hA0),       1, 0, z));
    tbl.push_back(mk(1, word(RD, 8'h40, 0),            1, 0, z));
    tbl.push_back(mk(1, word(WR, 8'h41, 32'hA1),       1, 1, word(RD, 8'h40, 32'hA0)));
    tbl.push_back(mk(1, word(RD, 8'h41, 0) | junk,     1, 0, z));
    tbl.push_back(mk(1, word(NOP, 8'h41, 32'h99),      1, 1, word(RD, 8'h41, 32'hA1)));
    tbl.push_back(mk(0, z,                             1, 0, z));

    rst = 1'b1;
    drive(0, z, 1);
    tick;
    tick;
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].mr);
      chk_out($sformatf("vec%0d", i), tbl[i].er, tbl[i].ev, tbl[i].ed);
      tick;
    end

    // Fill the FIFO with the consumer stalled.
    drive(1, word(RD, 8'h40, 0), 0); tick;
    drive(1, word(RD, 8'h41, 0), 0); tick;
    drive(1, word(RD, 8'h12, 0), 0); tick;
    drive(1, word(RD, 8'h01, 0), 0); tick;
    drive(1, word(WR, 8'h50, 32'h55), 0);
    for (int k = 0; k < 3; k++) begin
      chk_out($sformatf("full%0d", k), 0, 1, word(RD, 8'h40, 32'hA0));
      tick;
    end
    miso_ready_i = 1'b1;
    chk_out("drain0", 0, 1, word(RD, 8'h40, 32'hA0));
    tick;
    chk_out("drain1", 1, 1, word(RD, 8'h41, 32'hA1));
    tick;
    drive(0, z, 1);
    chk_out("drain2", 1, 1, word(RD, 8'h12, 32'hDEADBEEF));
    tick;
    chk_out("drain3", 1, 1, word(RD, 8'h01, 32'h1));
    tick;
    chk_out("drained", 1, 0, z);
    drive(1, word(RD, 8'h50, 0), 1); tick;
    drive(1, word(ST, 8'h00, 0), 1);
    chk_out("held_wr", 1, 1, word(RD, 8'h50, 32'h55));
    tick;
    drive(0, z, 1);
    chk_out("wcnt6", 1, 1, word(ST, 8'h00, 32'd6));
    tick;

    // Reset with responses queued and a command on the bus.
    drive(1, word(RD, 8'h12, 0), 0); tick;
    drive(1, word(RD, 8'h01, 0), 0); tick;
    chk("pre_rst valid", W'(miso_valid_o), W'(1'b1));
    rst = 1'b1;
    drive(1, word(WR, 8'h60, 32'h77), 0);
    tick;
    rst = 1'b0;
    drive(0, z, 1);
    chk_out("post_rst", 1, 0, z);
    drive(1, word(RD, 8'h12, 0), 1); tick;
    drive(1, word(RD, 8'h60, 0), 1);
    chk_out("rst_mem12", 1, 1, word(RD, 8'h12, 0));
    tick;
    drive(1, word(ST, 8'h00, 0), 1);
    chk_out("rst_mem60", 1, 1, word(RD, 8'h60, 0));
    tick;
    drive(0, z, 1);
    chk_out("rst_wcnt", 1, 1, word(ST, 8'h00, 0));
    tick;
    chk_out("final", 1, 0, z);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
